fft_frame_sequencer: RTL and testbench
======================================

// Module: fft_frame_sequencer
// PURPOSE
//   Top-level frame controller for the radix-2 FFT path. It drives one frame through
//   three steps in order: load (serial_init), compute (FFT core), then unload (serial_output).
//   It issues the start pulses, waits for each stage's completion, counts output beats,
//   and flags protocol errors to the host.
// PARAMETERS
//   N            16     FFT points per frame; output beats expected per frame (power of 2, >=2)
//   FCW          8      width of the frame counter
//   WDOG_CYCLES  4096   per-stage watchdog limit in clk cycles (used only with FFT_TIMEOUT_EN)
// PORTS
//   clk        in   1        system clock, rising edge
//   rst_n      in   1        asynchronous reset, active low
//   frame_req  in   1        host one-cycle pulse: process a new frame
//   clr_err    in   1        one-cycle pulse: clear the sticky error flags
//   load_start out  1        one-cycle pulse to loader new_data
//   load_done  in   1        loader completion pulse
//   fft_start  out  1        one-cycle pulse to FFT core start
//   fft_done   in   1        FFT core completion pulse
//   out_start  out  1        one-cycle pulse to serializer start
//   out_valid  in   1        serializer beat strobe (one per output sample)
//   busy       out  1        high in every state except IDLE
//   frame_done out  1        one-cycle pulse when a frame completes
//   frame_cnt  out  FCW      number of completed frames, wraps modulo 2^FCW
//   overrun    out  1        sticky: frame_req was received while busy
//   timeout    out  1        sticky: a stage exceeded WDOG_CYCLES
//   state_dbg  out  3        current state encoding
// BEHAVIOUR
//   Reset (rst_n low, async): state=IDLE; every output is 0; beat counter is 0.
//   All outputs are registered. Each start pulse is high for exactly the first cycle after
//   its state is entered.
//   FSM:
//     IDLE     -> LOAD     on frame_req. load_start is high in cycle t+1.
//     LOAD     -> COMPUTE  on load_done. fft_start is high in the next cycle.
//     COMPUTE  -> UNLOAD   on fft_done. out_start is high in the next cycle; beat counter is cleared.
//     UNLOAD   -> DONE     when the N-th out_valid beat is received.
//                          The beat counter is $clog2(N)+1 bits wide.
//     DONE     -> IDLE     after 1 cycle. frame_done is high and frame_cnt increments
//                          during this cycle; frame_cnt wraps from 2^FCW-1 to 0.
//   Boundary rules:
//   - Earliest re-accept: frame_req in the cycle after DONE is accepted (DONE->IDLE->LOAD).
//   - frame_req in any state other than IDLE (including DONE) is dropped; overrun <= 1.
//   - A completion strobe outside its own state is ignored. This covers load_done outside
//     LOAD, fft_done outside COMPUTE, and out_valid outside UNLOAD; none affect state or counters.
//   - load_done and frame_req in the same cycle while in LOAD: advance to COMPUTE and set overrun.
//   - clr_err and a new error in the same cycle: the error wins and the flag stays 1.
//   - rst_n asserted mid-frame: abort immediately to IDLE; frame_cnt and the flags are cleared.
// CONFIGURATION
//   FFT_TIMEOUT_EN defined:
//   - A watchdog counter clears on every state entry and increments in LOAD, COMPUTE and UNLOAD.
//   - At count == WDOG_CYCLES-1 without the exit condition, the FSM goes to IDLE and timeout <= 1.
//     No frame_done is issued and frame_cnt does not increment.
//   - The aborted frame's start pulses are not reissued.
//   FFT_TIMEOUT_EN undefined: no watchdog logic exists; timeout is tied to 0; stages wait forever.
// STRUCTURE
//   Package fft_seq_pkg:
//   - state encodings: IDLE=3'd0, LOAD=3'd1, COMPUTE=3'd2, UNLOAD=3'd3, DONE=3'd4
//   - beat counter width function
//   Sub-module fft_seq_watchdog: cycle counter with clr, en and expired output.
//   It is instantiated only under FFT_TIMEOUT_EN.
//   All FSM, pulse and counter logic lives in fft_frame_sequencer.
// TESTING (N=16, FCW=8, WDOG_CYCLES=64)
//   1. Nominal frame:
//      frame_req at t0 -> load_start at t0+1.
//      load_done at t5 -> fft_start at t6.
//      fft_done at t10 -> out_start at t11.
//      16 out_valid beats -> frame_done 1 cycle after the 16th beat; frame_cnt=1; busy=0 after.
//   2. Overrun: frame_req pulsed during COMPUTE -> overrun=1 and the frame completes normally.
//      clr_err -> overrun=0.
//   3. Stray strobes: fft_done and 5 out_valid in IDLE -> state stays IDLE (state_dbg=0),
//      frame_cnt is unchanged, no pulses.
//   4. Wrap: 256 back-to-back frames -> frame_cnt returns to 0; frame_req the cycle after
//      each DONE is accepted.
//   5. Mid-frame reset: rst_n low during UNLOAD after 7 beats -> all outputs are 0
//      asynchronously; the next frame needs 16 fresh beats.
//   6. FFT_TIMEOUT_EN: fft_done withheld -> 64 cycles into COMPUTE the FSM is in IDLE,
//      timeout=1, frame_cnt is unchanged. Without the macro -> timeout stays 0 and the FSM
//      stays in COMPUTE.

Source files
------------

// File: rtl/fft_seq_pkg.sv
// Shared definitions for the FFT frame sequencer.
//   state_t     : FSM state encoding (also exported on state_dbg)
//   beat_cnt_w  : width of the output-beat counter for an N-point frame
package fft_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_COMPUTE = 3'd2,
      ST_UNLOAD  = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   // One extra bit so the counter can represent N itself.
   function automatic int beat_cnt_w(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/fft_seq_watchdog.sv
// Per-stage cycle watchdog for the FFT frame sequencer.
//   clk, rst_n : clock, async active-low reset
//   clr        : restart the count at 0 (stage entry)
//   en         : count this cycle
//   expired    : count has reached LIMIT-1
module fft_seq_watchdog #(
   parameter int LIMIT = 4096
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [CW-1:0] count;

   assign expired = (count == CW'(LIMIT - 1));

   // Saturates at LIMIT-1; the sequencer leaves the stage on that cycle anyway.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && !expired) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame controller for the radix-2 FFT path: load -> compute -> unload.
// Optional per-stage watchdog enabled by defining FFT_TIMEOUT_EN.
//
// state      | meaning
// -----------+---------------------------------------------
// IDLE    0  | waiting for frame_req
// LOAD    1  | loader running, waiting for load_done
// COMPUTE 2  | FFT core running, waiting for fft_done
// UNLOAD  3  | serializer running, counting N out_valid beats
// DONE    4  | one cycle: frame_done pulse, frame_cnt bumped
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   frame_req, clr_err                 host request / sticky-error clear pulses
//   load_start/load_done               loader handshake
//   fft_start/fft_done                 FFT core handshake
//   out_start/out_valid                serializer handshake and beat strobe
//   busy, frame_done, frame_cnt        status
//   overrun, timeout                   sticky error flags
//   state_dbg                          current state encoding
module fft_frame_sequencer
   import fft_seq_pkg::*;
#(
   parameter int N           = 16,
   parameter int FCW         = 8,
   parameter int WDOG_CYCLES = 4096
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           frame_req,
   input  logic           clr_err,
   output logic           load_start,
   input  logic           load_done,
   output logic           fft_start,
   input  logic           fft_done,
   output logic           out_start,
   input  logic           out_valid,
   output logic           busy,
   output logic           frame_done,
   output logic [FCW-1:0] frame_cnt,
   output logic           overrun,
   output logic           timeout,
   output logic [2:0]     state_dbg
);

   localparam int BW = beat_cnt_w(N);

   if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
      $error("fft_frame_sequencer: N must be a power of two >= 2");
   end
   if (WDOG_CYCLES < 2) begin : g_bad_wdog
      $error("fft_frame_sequencer: WDOG_CYCLES must be >= 2");
   end

   state_t        state;
   logic [BW-1:0] beat_cnt;
   logic          last_beat;
   logic          advance;
   logic          abort;

   assign state_dbg = state;
   assign last_beat = (beat_cnt == BW'(N - 1));

   // The current stage's exit condition holds this cycle.
   always_comb begin
      advance = 1'b0;
      case (state)
         ST_IDLE:    advance = frame_req;
         ST_LOAD:    advance = load_done;
         ST_COMPUTE: advance = fft_done;
         ST_UNLOAD:  advance = out_valid && last_beat;
         ST_DONE:    advance = 1'b1;
         default:    advance = 1'b0;
      endcase
   end

`ifdef FFT_TIMEOUT_EN
   logic wd_en;
   logic wd_expired;

   assign wd_en = (state == ST_LOAD) || (state == ST_COMPUTE) || (state == ST_UNLOAD);
   assign abort = wd_en && wd_expired && !advance;

   // Every exit is also the next state's entry, so advance restarts the count.
   fft_seq_watchdog #(.LIMIT(WDOG_CYCLES)) u_wdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (advance),
      .en      (wd_en),
      .expired (wd_expired)
   );
`else
   assign abort   = 1'b0;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         beat_cnt   <= '0;
         load_start <= 1'b0;
         fft_start  <= 1'b0;
         out_start  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
         overrun    <= 1'b0;
`ifdef FFT_TIMEOUT_EN
         timeout    <= 1'b0;
`endif
      end else begin
         load_start <= 1'b0;
         fft_start  <= 1'b0;
         out_start  <= 1'b0;
         frame_done <= 1'b0;

         // Later assignments win: a new error beats a simultaneous clear.
         if (clr_err) overrun <= 1'b0;
         if (frame_req && state != ST_IDLE) overrun <= 1'b1;
`ifdef FFT_TIMEOUT_EN
         if (clr_err) timeout <= 1'b0;
         if (abort)   timeout <= 1'b1;
`endif

         if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: if (frame_req) begin
                  state      <= ST_LOAD;
                  busy       <= 1'b1;
                  load_start <= 1'b1;
               end
               ST_LOAD: if (load_done) begin
                  state     <= ST_COMPUTE;
                  fft_start <= 1'b1;
               end
               ST_COMPUTE: if (fft_done) begin
                  state     <= ST_UNLOAD;
                  out_start <= 1'b1;
                  beat_cnt  <= '0;
               end
               ST_UNLOAD: if (out_valid) begin
                  if (last_beat) begin
                     state      <= ST_DONE;
                     frame_done <= 1'b1;
                     frame_cnt  <= frame_cnt + 1'b1;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
               ST_DONE: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer (N=16, FCW=8, WDOG_CYCLES=64).
// Table of directed per-cycle vectors plus hand-written multi-cycle sequences.
module tb_fft_frame_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       frame_req, clr_err, load_done, fft_done, out_valid;
   logic       load_start, fft_start, out_start, busy, frame_done, overrun, timeout;
   logic [7:0] frame_cnt;
   logic [2:0] state_dbg;

   int n_vec = 0;
   int n_err = 0;

   fft_frame_sequencer #(.N(16), .FCW(8), .WDOG_CYCLES(64)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_req  (frame_req),
      .clr_err    (clr_err),
      .load_start (load_start),
      .load_done  (load_done),
      .fft_start  (fft_start),
      .fft_done   (fft_done),
      .out_start  (out_start),
      .out_valid  (out_valid),
      .busy       (busy),
      .frame_done (frame_done),
      .frame_cnt  (frame_cnt),
      .overrun    (overrun),
      .timeout    (timeout),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       fr, ld, fd, ov, ce;
      logic [2:0] st;
      logic       ls, fs, os, fdn;
      logic [7:0] cnt;
      logic       orun;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic fr, ld, fd, ov, ce,
                               input logic [2:0] st,
                               input logic ls, fs, os, fdn,
                               input logic [7:0] cnt,
                               input logic orun);
      vec_t v;
      v.fr = fr; v.ld = ld; v.fd = fd; v.ov = ov; v.ce = ce;
      v.st = st; v.ls = ls; v.fs = fs; v.os = os; v.fdn = fdn;
      v.cnt = cnt; v.orun = orun;
      tbl.push_back(v);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic drive(input logic fr, ld, fd, ov, ce);
      frame_req = fr; load_done = ld; fft_done = fd; out_valid = ov; clr_err = ce;
   endtask

   // Full frame from IDLE with minimal stage latency; checks accept and completion.
   task automatic run_frame(input logic [7:0] exp_cnt);
      drive(1, 0, 0, 0, 0); step();
      chk("wrap_accept", {29'd0, state_dbg}, 32'd1);
      drive(0, 1, 0, 0, 0); step();
      drive(0, 0, 1, 0, 0); step();
      drive(0, 0, 0, 1, 0);
      repeat (16) step();
      drive(0, 0, 0, 0, 0);
      chk("wrap_done", {20'd0, state_dbg, frame_done, frame_cnt},
          {20'd0, 3'd4, 1'b1, exp_cnt});
      step();
      chk("wrap_idle", {30'd0, state_dbg == 3'd0, busy}, {30'd0, 1'b1, 1'b0});
   endtask

   initial begin
      // Nominal frame: load_done 5 cycles after frame_req, fft_done 5 after that.
      add(1,0,0,0,0, 1, 1,0,0,0, 0, 0);
      for (int i = 0; i < 4; i++) add(0,0,0,0,0, 1, 0,0,0,0, 0, 0);
      add(0,1,0,0,0, 2, 0,1,0,0, 0, 0);
      for (int i = 0; i < 4; i++) add(0,0,0,0,0, 2, 0,0,0,0, 0, 0);
      add(0,0,1,0,0, 3, 0,0,1,0, 0, 0);
      for (int i = 0; i < 15; i++) add(0,0,0,1,0, 3, 0,0,0,0, 0, 0);
      add(0,0,0,1,0, 4, 0,0,0,1, 1, 0);
      add(0,0,0,0,0, 0, 0,0,0,0, 1, 0);
      // Stray strobes in IDLE.
      add(0,0,1,0,0, 0, 0,0,0,0, 1, 0);
      for (int i = 0; i < 5; i++) add(0,0,0,1,0, 0, 0,0,0,0, 1, 0);
      add(0,1,0,0,0, 0, 0,0,0,0, 1, 0);
      add(0,0,0,0,1, 0, 0,0,0,0, 1, 0);
      // Overrun and boundary cases.
      add(1,0,0,0,0, 1, 1,0,0,0, 1, 0);
      add(1,1,0,0,0, 2, 0,1,0,0, 1, 1);   // load_done + frame_req in LOAD
      add(0,0,0,0,1, 2, 0,0,0,0, 1, 0);   // clear
      add(1,0,0,0,1, 2, 0,0,0,0, 1, 1);   // clear vs new error: error wins
      add(0,0,0,1,0, 2, 0,0,0,0, 1, 1);   // stray out_valid
      add(0,1,0,0,0, 2, 0,0,0,0, 1, 1);   // stray load_done
      add(0,0,1,0,0, 3, 0,0,1,0, 1, 1);
      add(0,0,1,0,0, 3, 0,0,0,0, 1, 1);   // stray fft_done
      for (int i = 0; i < 15; i++) add(0,0,0,1,0, 3, 0,0,0,0, 1, 1);
      add(0,0,0,1,0, 4, 0,0,0,1, 2, 1);
      add(1,0,0,0,0, 0, 0,0,0,0, 2, 1);   // frame_req in DONE dropped
      add(1,0,0,0,0, 1, 1,0,0,0, 2, 1);   // accepted in cycle after DONE
      add(0,0,0,0,1, 1, 0,0,0,0, 2, 0);
      add(0,1,0,0,0, 2, 0,1,0,0, 2, 0);
      add(0,0,1,0,0, 3, 0,0,1,0, 2, 0);
      for (int i = 0; i < 15; i++) add(0,0,0,1,0, 3, 0,0,0,0, 2, 0);
      add(0,0,0,1,0, 4, 0,0,0,1, 3, 0);
      add(0,0,0,0,0, 0, 0,0,0,0, 3, 0);

      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0);
      step(); step();
      chk("reset_outputs",
          {14'd0, state_dbg, busy, load_start, fft_start, out_start, frame_done, frame_cnt, overrun, timeout},
          32'd0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].fr, tbl[i].ld, tbl[i].fd, tbl[i].ov, tbl[i].ce);
         step();
         chk($sformatf("vec%0d", i),
             {14'd0, state_dbg, busy, load_start, fft_start, out_start, frame_done, frame_cnt, overrun, timeout},
             {14'd0, tbl[i].st, tbl[i].st != 3'd0, tbl[i].ls, tbl[i].fs, tbl[i].os, tbl[i].fdn,
              tbl[i].cnt, tbl[i].orun, 1'b0});
      end
      drive(0, 0, 0, 0, 0);

      // Mid-frame reset after 7 beats of UNLOAD.
      drive(1, 0, 0, 0, 0); step();
      drive(0, 1, 0, 0, 0); step();
      drive(0, 0, 1, 0, 0); step();
      drive(0, 0, 0, 1, 0); repeat (7) step();
      drive(0, 0, 0, 0, 0);
      chk("pre_reset_unload", {29'd0, state_dbg}, 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_outputs",
          {14'd0, state_dbg, busy, load_start, fft_start, out_start, frame_done, frame_cnt, overrun, timeout},
          32'd0);
      step();
      rst_n = 1'b1;
      step();
      drive(1, 0, 0, 0, 0); step();
      drive(0, 1, 0, 0, 0); step();
      drive(0, 0, 1, 0, 0); step();
      drive(0, 0, 0, 1, 0); repeat (15) step();
      chk("fresh_beats_15", {21'd0, state_dbg, frame_cnt}, {21'd0, 3'd3, 8'd0});
      step();
      drive(0, 0, 0, 0, 0);
      chk("fresh_beats_16", {20'd0, state_dbg, frame_done, frame_cnt}, {20'd0, 3'd4, 1'b1, 8'd1});
      step();

      // Back-to-back frames through the frame_cnt wrap (1 -> 255 -> 0).
      for (int f = 2; f <= 256; f++) run_frame(8'(f));
      chk("wrap_zero", {24'd0, frame_cnt}, 32'd0);

      // Withheld fft_done.
      drive(1, 0, 0, 0, 0); step();
      drive(0, 1, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0);
`ifdef FFT_TIMEOUT_EN
      repeat (63) step();
      chk("wdog_last_compute", {28'd0, state_dbg, timeout}, {28'd0, 3'd2, 1'b0});
      step();
      chk("wdog_abort",
          {18'd0, state_dbg, busy, timeout, frame_done, frame_cnt},
          {18'd0, 3'd0, 1'b0, 1'b1, 1'b0, 8'd0});
      step();
      chk("wdog_no_reissue", {28'd0, state_dbg, load_start, fft_start, out_start},
          {28'd0, 3'd0, 1'b0, 1'b0, 1'b0});
      drive(0, 0, 0, 0, 1); step();
      drive(0, 0, 0, 0, 0);
      chk("wdog_clr", {31'd0, timeout}, 32'd0);
`else
      repeat (100) step();
      chk("no_wdog_stays", {28'd0, state_dbg, timeout}, {28'd0, 3'd2, 1'b0});
      drive(0, 0, 1, 0, 0); step();
      drive(0, 0, 0, 1, 0); repeat (16) step();
      drive(0, 0, 0, 0, 0);
      chk("no_wdog_done", {20'd0, state_dbg, frame_done, frame_cnt}, {20'd0, 3'd4, 1'b1, 8'd1});
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
